// File: rtl/port_afu_rst_sequencer.sv
// port_afu_rst_sequencer: per-port AFU reset sequencing with TX drain, timeout and global mode
module port_afu_rst_sequencer #(
    parameter int PG_NUM_PORTS  = 4,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int GLOBAL_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PG_NUM_PORTS-1:0] rst_req,
    input  logic [PG_NUM_PORTS-1:0] tx_a_tvalid,
    input  logic [PG_NUM_PORTS-1:0] tx_a_tready,
    input  logic [PG_NUM_PORTS-1:0] tx_a_tlast,
    input  logic [PG_NUM_PORTS-1:0] tx_b_tvalid,
    input  logic [PG_NUM_PORTS-1:0] tx_b_tready,
    input  logic [PG_NUM_PORTS-1:0] tx_b_tlast,
    output logic [PG_NUM_PORTS-1:0] tx_gate,
    output logic [PG_NUM_PORTS-1:0] port_rst_n,
    output logic [PG_NUM_PORTS-1:0] port_busy,
    output logic [PG_NUM_PORTS-1:0] rst_done,
    output logic [PG_NUM_PORTS-1:0] drain_timeout
);
    localparam int N   = PG_NUM_PORTS;
    localparam int MX0 = RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES;
    localparam int MX  = MX0 > DRAIN_TIMEOUT ? MX0 : DRAIN_TIMEOUT;
    localparam int CW  = $clog2(MX) + 1;
    localparam logic [CW-1:0] R_END = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] S_END = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] D_END = CW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HOLD, RELEASE} state_t;

    state_t        st     [N];
    state_t        st_nx  [N];
    logic [CW-1:0] cnt    [N];
    logic [CW-1:0] cnt_nx [N];
    logic [N-1:0]  in_a, in_b, in_a_nx, in_b_nx, clr;
    logic [N-1:0]  pend, pend_nx, dto, dto_nx;
    logic [N-1:0]  req, drained, tmo, ex;
    logic          all_dr;

    // next-state, counters, in-packet tracking and outputs for every port
    always_comb begin
        req     = GLOBAL_MODE != 0 ? {N{|rst_req}} : rst_req;
        in_a_nx = (tx_a_tvalid & tx_a_tready & ~tx_a_tlast) | (~(tx_a_tvalid & tx_a_tready) & in_a);
        in_b_nx = (tx_b_tvalid & tx_b_tready & ~tx_b_tlast) | (~(tx_b_tvalid & tx_b_tready) & in_b);
        drained = ~in_a_nx & ~in_b_nx;
        all_dr  = &drained;
        for (int i = 0; i < N; i++) begin
            st_nx[i]      = st[i];
            cnt_nx[i]     = &cnt[i] ? cnt[i] : cnt[i] + 1'b1;
            pend_nx[i]    = pend[i];
            dto_nx[i]     = dto[i] & ~req[i];
            tmo[i]        = DRAIN_TIMEOUT != 0 && cnt[i] == D_END;
            ex[i]         = GLOBAL_MODE != 0 ? all_dr : drained[i];
            case (st[i])
                RUN: begin
                    cnt_nx[i] = '0;
                    if (req[i] | pend[i]) begin
                        st_nx[i]   = DRAIN;
                        pend_nx[i] = 1'b0;
                    end
                end
                DRAIN: if (ex[i] | tmo[i]) begin
                    st_nx[i]  = HOLD;
                    cnt_nx[i] = '0;
                    dto_nx[i] = dto_nx[i] | (tmo[i] & ~drained[i]);
                end
                HOLD: if (cnt[i] == R_END) begin
                    st_nx[i]  = RELEASE;
                    cnt_nx[i] = '0;
                end
                RELEASE: begin
                    pend_nx[i] = pend[i] | req[i];
                    if (cnt[i] == S_END) begin
                        st_nx[i]  = RUN;
                        cnt_nx[i] = '0;
                    end
                end
            endcase
            clr[i]           = st[i] == HOLD || st_nx[i] == HOLD;
            tx_gate[i]       = st[i] == RUN || in_a[i] || in_b[i];
            port_rst_n[i]    = st[i] != HOLD;
            port_busy[i]     = st[i] != RUN;
            rst_done[i]      = st[i] == RELEASE && cnt[i] == S_END;
        end
        drain_timeout = dto;
    end

    // state registers; reset parks every port in HOLD so power-up follows the normal release flow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                st[i]  <= HOLD;
                cnt[i] <= '0;
            end
            in_a <= '0;
            in_b <= '0;
            pend <= '0;
            dto  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                st[i]  <= st_nx[i];
                cnt[i] <= cnt_nx[i];
            end
            in_a <= in_a_nx & ~clr;
            in_b <= in_b_nx & ~clr;
            pend <= pend_nx;
            dto  <= dto_nx;
        end
    end
endmodule
